// File: rtl/minibyte_pkg.sv
// minibyte_pkg: shared opcode, ALU and state encodings for the minibyte CPU
package minibyte_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDM  = 4'h2;
  localparam logic [3:0] OP_STM  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SUBI = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_XORI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_BN   = 4'hB;
  localparam logic [3:0] OP_ADDM = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_PASS_A = 3'd1;
  localparam logic [2:0] ALU_ADD    = 3'd2;
  localparam logic [2:0] ALU_SUB    = 3'd3;
  localparam logic [2:0] ALU_AND    = 3'd4;
  localparam logic [2:0] ALU_OR     = 3'd5;
  localparam logic [2:0] ALU_XOR    = 3'd6;
  localparam logic [2:0] ALU_NOT_A  = 3'd7;
  typedef enum logic [2:0] {S_RESET, S_FETCH, S_OPER, S_EXEC, S_HALT} state_e;
  function automatic logic is_illegal(input logic [3:0] op);
    return op == 4'hD || op == 4'hE;
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op == OP_LDM || op == OP_STM || op == OP_ADDM;
  endfunction
endpackage

// File: rtl/minibyte_ctrl_decode.sv
// minibyte_ctrl_decode: next-state and Moore control-word decode for the minibyte controller
module minibyte_ctrl_decode
  import minibyte_pkg::*;
#(
  parameter int ILLEGAL_HALTS = 0
) (
  input  logic [2:0] state_i,
  input  logic [3:0] ir_op_i,
  input  logic [3:0] data_op_i,
  input  logic       flag_z_i,
  input  logic       flag_n_i,
  output logic [2:0] state_d_o,
  output logic       set_a_o,
  output logic       set_m_o,
  output logic       set_pc_o,
  output logic       inc_pc_o,
  output logic       addr_mux_o,
  output logic [2:0] alu_op_o,
  output logic       we_o,
  output logic       halt_o
);
  logic taken;
  assign taken = (ir_op_i == OP_BZ) ? flag_z_i : flag_n_i;
  // Sequencing: fetch decides from the opcode on the bus, operand cycle from the latched IR
  always_comb begin
    state_d_o = S_RESET;
    case (state_i)
      S_RESET: state_d_o = S_FETCH;
      S_FETCH: state_d_o = (data_op_i == OP_HLT || (ILLEGAL_HALTS != 0 && is_illegal(data_op_i))) ? S_HALT :
                           (data_op_i == OP_NOP || is_illegal(data_op_i)) ? S_FETCH : S_OPER;
      S_OPER:  state_d_o = is_mem(ir_op_i) ? S_EXEC : S_FETCH;
      S_EXEC:  state_d_o = S_FETCH;
      S_HALT:  state_d_o = S_HALT;
      default: state_d_o = S_RESET;
    endcase
  end
  // Control lines depend only on state, IR and latched flags, so reset kills them at once
  always_comb begin
    {set_a_o, set_m_o, set_pc_o, inc_pc_o, addr_mux_o, we_o, halt_o} = '0;
    alu_op_o = ALU_PASS_B;
    case (state_i)
      S_FETCH: inc_pc_o = 1'b1;
      S_OPER:
        case (ir_op_i)
          OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
            set_a_o  = 1'b1;
            inc_pc_o = 1'b1;
            alu_op_o = (ir_op_i == OP_LDI) ? ALU_PASS_B : 3'(ir_op_i - 4'd2);
          end
          OP_LDM, OP_STM, OP_ADDM: begin
            set_m_o  = 1'b1;
            inc_pc_o = 1'b1;
          end
          OP_JMP: set_pc_o = 1'b1;
          OP_BZ, OP_BN: begin
            set_pc_o = taken;
            inc_pc_o = !taken;
          end
          default: ;
        endcase
      S_EXEC: begin
        addr_mux_o = 1'b1;
        set_a_o    = ir_op_i != OP_STM;
        we_o       = ir_op_i == OP_STM;
        alu_op_o   = (ir_op_i == OP_STM) ? ALU_PASS_A : (ir_op_i == OP_ADDM) ? ALU_ADD : ALU_PASS_B;
      end
      S_HALT: halt_o = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/minibyte_control.sv
// minibyte_control: fetch/operand/exec sequencer holding state, IR and branch flags
module minibyte_control
  import minibyte_pkg::*;
#(
  parameter int ILLEGAL_HALTS = 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       flag_z_in,
  input  logic       flag_n_in,
  output logic       ctrl_set_a,
  output logic       ctrl_set_m,
  output logic       ctrl_set_pc,
  output logic       ctrl_inc_pc,
  output logic       ctrl_addr_mux,
  output logic [2:0] ctrl_alu_op,
  output logic       ctrl_we_out,
  output logic       halt_out
);
  logic [2:0] state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic       unused_ir_lo;
  assign unused_ir_lo = ^ir_q[3:0];
  // IR captures the opcode byte during fetch; flags follow the ALU whenever A is loaded
  always_comb begin
    ir_d     = (state_q == S_FETCH) ? data_in : ir_q;
    flag_z_d = ctrl_set_a ? flag_z_in : flag_z_q;
    flag_n_d = ctrl_set_a ? flag_n_in : flag_n_q;
  end
  // State, IR and flag registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_RESET;
      ir_q     <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end
  minibyte_ctrl_decode #(.ILLEGAL_HALTS(ILLEGAL_HALTS)) u_decode (
    .state_i    (state_q),
    .ir_op_i    (ir_q[7:4]),
    .data_op_i  (data_in[7:4]),
    .flag_z_i   (flag_z_q),
    .flag_n_i   (flag_n_q),
    .state_d_o  (state_d),
    .set_a_o    (ctrl_set_a),
    .set_m_o    (ctrl_set_m),
    .set_pc_o   (ctrl_set_pc),
    .inc_pc_o   (ctrl_inc_pc),
    .addr_mux_o (ctrl_addr_mux),
    .alu_op_o   (ctrl_alu_op),
    .we_o       (ctrl_we_out),
    .halt_o     (halt_out)
  );
endmodule

// File: tb/tb_minibyte_control.sv
// tb_minibyte_control: directed and randomized checks of the minibyte controller against an instruction-level model
module tb_minibyte_control;
  localparam logic [9:0] SA = 10'h001, SM = 10'h002, SP = 10'h004, INC = 10'h008;
  localparam logic [9:0] MUX = 10'h010, WE = 10'h100, HLT = 10'h200;
  logic clk = 1'b0, rst_in = 1'b0, flag_z_in = 1'b0, flag_n_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic ctrl_set_a, ctrl_set_m, ctrl_set_pc, ctrl_inc_pc, ctrl_addr_mux, ctrl_we_out, halt_out;
  logic [2:0] ctrl_alu_op;
  logic [9:0] cw;
  int checks = 0, failures = 0;
  assign cw = {halt_out, ctrl_we_out, ctrl_alu_op, ctrl_addr_mux, ctrl_inc_pc, ctrl_set_pc, ctrl_set_m, ctrl_set_a};
  always #5 clk = ~clk;
  minibyte_control dut (
    .clk_in(clk), .rst_in(rst_in), .data_in(data_in), .flag_z_in(flag_z_in), .flag_n_in(flag_n_in),
    .ctrl_set_a(ctrl_set_a), .ctrl_set_m(ctrl_set_m), .ctrl_set_pc(ctrl_set_pc), .ctrl_inc_pc(ctrl_inc_pc),
    .ctrl_addr_mux(ctrl_addr_mux), .ctrl_alu_op(ctrl_alu_op), .ctrl_we_out(ctrl_we_out), .halt_out(halt_out)
  );
  function automatic logic [9:0] alu(input int a);
    return 10'(a) << 5;
  endfunction
  // Expected control word for cycle ph of an instruction, straight from the instruction table
  function automatic logic [9:0] model(input logic [3:0] op, input int ph, input logic z, input logic n);
    if (ph == 0) return INC;
    if (ph == 1)
      case (op)
        4'h1: return SA | INC | alu(0);
        4'h4: return SA | INC | alu(2);
        4'h5: return SA | INC | alu(3);
        4'h6: return SA | INC | alu(4);
        4'h7: return SA | INC | alu(5);
        4'h8: return SA | INC | alu(6);
        4'h2, 4'h3, 4'hC: return SM | INC;
        4'h9: return SP;
        4'hA: return z ? SP : INC;
        4'hB: return n ? SP : INC;
        default: return 10'h000;
      endcase
    case (op)
      4'h2: return MUX | SA;
      4'h3: return MUX | WE | alu(1);
      4'hC: return MUX | SA | alu(2);
      default: return 10'h000;
    endcase
  endfunction
  function automatic int cycles(input logic [3:0] op);
    return (op == 4'h0 || op == 4'hD || op == 4'hE) ? 1 : (op == 4'h2 || op == 4'h3 || op == 4'hC) ? 3 : 2;
  endfunction
  task automatic set_in(input logic [7:0] d, input logic z, input logic n);
    data_in = d;
    flag_z_in = z;
    flag_n_in = n;
  endtask
  task automatic adv;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_in = 1'b0;
    set_in(8'h00, 1'b0, 1'b0);
    adv;
    checks++; if (cw !== 10'h000) begin failures++; $display("FAIL reset_hold got=%h exp=%h", cw, 10'h000); end
    rst_in = 1'b1;
    checks++; if (cw !== 10'h000) begin failures++; $display("FAIL reset_first_cycle got=%h exp=%h", cw, 10'h000); end
    adv;
    set_in(8'h10, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL ldi_fetch got=%h exp=%h", cw, INC); end
    adv;
    set_in(8'h5A, 1'b0, 1'b0);
    checks++; if (cw !== (SA | INC)) begin failures++; $display("FAIL ldi_oper got=%h exp=%h", cw, SA | INC); end
    adv;
  endtask
  task automatic test_stm;
    set_in(8'h30, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL stm_fetch got=%h exp=%h", cw, INC); end
    adv;
    set_in(8'h80, 1'b0, 1'b0);
    checks++; if (cw !== (SM | INC)) begin failures++; $display("FAIL stm_oper got=%h exp=%h", cw, SM | INC); end
    adv;
    set_in(8'($urandom), 1'b0, 1'b0);
    checks++; if (cw !== (MUX | WE | alu(1))) begin failures++; $display("FAIL stm_exec got=%h exp=%h", cw, MUX | WE | alu(1)); end
    adv;
    checks++; if (cw !== INC) begin failures++; $display("FAIL stm_we_one_cycle got=%h exp=%h", cw, INC); end
  endtask
  task automatic test_branch;
    for (int t = 0; t < 4; t++) begin
      logic z, n;
      z = t[0];
      n = t[1];
      set_in(8'h50, 1'b0, 1'b0);
      adv;
      set_in(8'h05, z, n);
      checks++; if (cw !== (SA | INC | alu(3))) begin failures++; $display("FAIL subi_oper t=%0d got=%h exp=%h", t, cw, SA | INC | alu(3)); end
      adv;
      set_in(8'hA0, 1'b0, 1'b0);
      adv;
      set_in(8'h40, 1'b0, 1'b0);
      checks++; if (cw !== (z ? SP : INC)) begin failures++; $display("FAIL bz_oper z=%0b got=%h exp=%h", z, cw, z ? SP : INC); end
      adv;
      set_in(8'hB0, 1'b0, 1'b0);
      adv;
      set_in(8'h44, 1'b0, 1'b0);
      checks++; if (cw !== (n ? SP : INC)) begin failures++; $display("FAIL bn_oper n=%0b got=%h exp=%h", n, cw, n ? SP : INC); end
      adv;
    end
  endtask
  task automatic test_illegal;
    set_in(8'hD0, 1'b0, 1'b0);
    adv;
    set_in(8'hE7, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL illegal_d_refetch got=%h exp=%h", cw, INC); end
    adv;
    set_in(8'h10, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL illegal_e_refetch got=%h exp=%h", cw, INC); end
    adv;
    set_in(8'h33, 1'b0, 1'b0);
    checks++; if (cw !== (SA | INC)) begin failures++; $display("FAIL ldi_after_illegal got=%h exp=%h", cw, SA | INC); end
    adv;
  endtask
  task automatic test_addm;
    set_in(8'hC0, 1'b0, 1'b0);
    adv;
    set_in(8'h20, 1'b0, 1'b0);
    checks++; if (cw !== (SM | INC)) begin failures++; $display("FAIL addm_oper got=%h exp=%h", cw, SM | INC); end
    adv;
    set_in(8'($urandom), 1'b0, 1'b1);
    checks++; if (cw !== (MUX | SA | alu(2))) begin failures++; $display("FAIL addm_exec got=%h exp=%h", cw, MUX | SA | alu(2)); end
    adv;
    set_in(8'hB0, 1'b0, 1'b0);
    adv;
    set_in(8'h10, 1'b0, 1'b0);
    checks++; if (cw !== SP) begin failures++; $display("FAIL bn_after_addm got=%h exp=%h", cw, SP); end
    adv;
    set_in(8'hA0, 1'b0, 1'b0);
    adv;
    set_in(8'h10, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL bz_after_addm got=%h exp=%h", cw, INC); end
    adv;
  endtask
  task automatic test_reset_mid_exec;
    set_in(8'h50, 1'b0, 1'b0);
    adv;
    set_in(8'h01, 1'b1, 1'b1);
    adv;
    set_in(8'h30, 1'b0, 1'b0);
    adv;
    set_in(8'h80, 1'b0, 1'b0);
    adv;
    checks++; if (cw !== (MUX | WE | alu(1))) begin failures++; $display("FAIL mid_stm_exec got=%h exp=%h", cw, MUX | WE | alu(1)); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (cw !== 10'h000) begin failures++; $display("FAIL we_async_drop got=%h exp=%h", cw, 10'h000); end
    @(posedge clk);
    #1 rst_in = 1'b1;
    checks++; if (cw !== 10'h000) begin failures++; $display("FAIL post_reset_state got=%h exp=%h", cw, 10'h000); end
    adv;
    set_in(8'hA0, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL post_reset_fetch got=%h exp=%h", cw, INC); end
    adv;
    set_in(8'h40, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL bz_after_reset got=%h exp=%h", cw, INC); end
    adv;
    set_in(8'hB0, 1'b0, 1'b0);
    adv;
    set_in(8'h40, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL bn_after_reset got=%h exp=%h", cw, INC); end
    adv;
  endtask
  task automatic test_random;
    logic mz, mn;
    logic [9:0] exp;
    rst_in = 1'b0;
    adv;
    rst_in = 1'b1;
    adv;
    mz = 1'b0;
    mn = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      for (int ph = 0; ph < cycles(op); ph++) begin
        set_in(ph == 0 ? {op, 4'($urandom)} : 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        exp = model(op, ph, mz, mn);
        checks++; if (cw !== exp) begin failures++; $display("FAIL random i=%0d op=%h ph=%0d got=%h exp=%h", i, op, ph, cw, exp); end
        if (exp[0]) begin
          mz = flag_z_in;
          mn = flag_n_in;
        end
        adv;
      end
    end
  endtask
  task automatic test_halt;
    set_in(8'hF0, 1'b0, 1'b0);
    checks++; if (cw !== INC) begin failures++; $display("FAIL hlt_fetch got=%h exp=%h", cw, INC); end
    adv;
    for (int i = 0; i < 20; i++) begin
      set_in(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++; if (cw !== HLT) begin failures++; $display("FAIL halt_hold cycle=%0d got=%h exp=%h", i, cw, HLT); end
      adv;
    end
  endtask
  initial begin
    test_reset;
    test_stm;
    test_branch;
    test_illegal;
    test_addm;
    test_reset_mid_exec;
    test_random;
    test_halt;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
